// File: rtl/axi_lsu.sv
// AXI4 single-beat load/store unit: lane steering, wstrb generation, load extension.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned or size-3 accesses into an error response with no bus traffic.
module axi_lsu #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 31,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic                resp_wen,
  output logic [31:0]         resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_err,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic [3:0]          arqos,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [LANE_W-1:0] lane_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done, w_done;

  logic              accept, trap;
  logic [1:0]        size_eff;
  logic [3:0]        strb_base;
  logic [STRB_W-1:0] wstrb_new;
  logic [31:0]       word_rep;
  logic              aw_hs, w_hs, r_fire, b_fire;
  logic [DATA_W-1:0] shifted;
  logic [31:0]       field, load_ext;
  logic              unused_bits;

  assign accept   = req_valid && req_ready;
  // Reserved size 3 behaves as a word everywhere downstream.
  assign size_eff = (req_size == 2'd3) ? 2'd2 : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (req_size == 2'd3) ||
                (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign strb_base = (size_eff == 2'd0) ? 4'h1 : (size_eff == 2'd1) ? 4'h3 : 4'hF;
  assign wstrb_new = STRB_W'(strb_base) << req_addr[LANE_W-1:0];
  // Sub-word data is replicated inside the word so every lane carries it at its byte offset.
  assign word_rep  = (size_eff == 2'd0) ? {4{req_wdata[7:0]}}  :
                     (size_eff == 2'd1) ? {2{req_wdata[15:0]}} : req_wdata;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign r_fire = rvalid && rready && (state == S_RDATA || arready);
  assign b_fire = bvalid && bready;

  assign shifted = rdata >> {lane_q, 3'b000};
  assign field   = shifted[31:0];
  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{sgn_q & field[7]}}, field[7:0]};
      2'd1:    load_ext = {{16{sgn_q & field[15]}}, field[15:0]};
      default: load_ext = field;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !trap) state_nxt = req_we ? S_WRITE : S_RADDR;
      end
      S_RADDR: begin
        arvalid = 1'b1;
        rready  = 1'b1;
        if (arready) state_nxt = r_fire ? S_IDLE : S_RDATA;
      end
      S_RDATA: begin
        rready = 1'b1;
        if (r_fire) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_wen   <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W-1:0];
        lane_q  <= req_addr[LANE_W-1:0];
        size_q  <= size_eff;
        sgn_q   <= req_signed;
        rd_q    <= req_rd;
        wdata_q <= {(DATA_W/32){word_rep}};
        wstrb_q <= wstrb_new;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (trap) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_wen   <= 1'b0;
          resp_data  <= '0;
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (r_fire) begin
        resp_valid <= 1'b1;
        resp_err   <= rresp[1];
        resp_wen   <= ~rresp[1];
        resp_data  <= load_ext;
      end
      if (b_fire) begin
        resp_valid <= 1'b1;
        resp_err   <= bresp[1];
        resp_wen   <= 1'b0;
        resp_data  <= '0;
      end
    end
  end

  assign resp_rd = rd_q;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  assign arid    = ID_W'(AXI_ID);
  assign awid    = ID_W'(AXI_ID);
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arcache = 4'b0011;
  assign awcache = 4'b0011;
  assign arlock  = 1'b0;
  assign awlock  = 1'b0;
  assign arprot  = 3'b000;
  assign awprot  = 3'b000;
  assign arqos   = 4'b0000;
  assign awqos   = 4'b0000;

  assign unused_bits = ^{rlast, rresp[0], bresp[0], req_addr};
endmodule

// File: tb/tb_axi_lsu.sv
// Directed self-checking bench for axi_lsu: loads, stores, lane steering, errors, reset, back-to-back.
module tb_axi_lsu;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 31;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid, resp_wen, resp_err;
  logic [31:0]       resp_data;
  logic [4:0]        resp_rd;
  logic [ID_W-1:0]   arid, awid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, arprot, awprot;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arlock, awlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]        arcache, awcache, arqos, awqos;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [STRB_W-1:0] wstrb;

  int checks = 0;
  int errors = 0;

  axi_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(0)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic set_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_rd = rd;
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    set_req(we, size, sgn, addr, wd, rd);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_accept got %b exp 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Zero-wait slave; reports the response and what was seen on the bus.
  task automatic run_slave(input logic [DATA_W-1:0] data, input logic [1:0] rr, input logic [1:0] br,
                           output logic ok, output int lat, output logic [31:0] d,
                           output logic e, output logic w, output logic saw_ar, output logic saw_aw,
                           output logic [DATA_W-1:0] cw, output logic [STRB_W-1:0] cs,
                           output logic [2:0] cz);
    ok = 1'b0; lat = 0; d = '0; e = 1'b0; w = 1'b0; saw_ar = 1'b0; saw_aw = 1'b0;
    cw = '0; cs = '0; cz = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (arvalid) begin saw_ar = 1'b1; cz = arsize; end
      if (awvalid) begin saw_aw = 1'b1; cz = awsize; end
      if (wvalid)  begin cw = wdata; cs = wstrb; end
      rdata = data; rresp = rr; bresp = br; rlast = 1'b1;
      arready = arvalid;
      rvalid  = rready && !arvalid;
      awready = awvalid;
      wready  = wvalid;
      bvalid  = bready;
      if (resp_valid) begin
        ok = 1'b1; lat = i; d = resp_data; e = resp_err; w = resp_wen;
        break;
      end
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL resp_timeout got 0 exp 1"); end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'b0) begin
      errors++; $display("FAIL rst_valids got %b exp 000000", {arvalid, awvalid, wvalid, rready, bready, resp_valid});
    end
    checks++;
    if ({araddr, awaddr, wstrb, resp_data, resp_err, resp_wen} !== '0 || wdata !== '0) begin
      errors++; $display("FAIL rst_data got araddr %h wstrb %h resp %h exp 0", araddr, wstrb, resp_data);
    end
    checks++;
    if ({arid, awid, arlen, awlen, arburst, awburst, arcache, awcache, arlock, awlock,
         arprot, awprot, arqos, awqos, wlast} !== {4'd0, 4'd0, 8'd0, 8'd0, 2'b01, 2'b01,
         4'b0011, 4'b0011, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL const_outputs got arburst %b arcache %b arlen %h exp 01 0011 00", arburst, arcache, arlen);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_load_word;
    logic [DATA_W-1:0] data;
    data = '0;
    data[31:0] = 32'hDEADBEEF;
    data[63:32] = 32'h01234567;
    send_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd7);
    @(negedge clk);
    checks++;
    if ({arvalid, rready, req_ready} !== 3'b110) begin
      errors++; $display("FAIL lw_t1_valids got %b exp 110", {arvalid, rready, req_ready});
    end
    checks++;
    if (araddr !== 31'h40 || arsize !== 3'd2) begin
      errors++; $display("FAIL lw_araddr got %h/%0d exp 40/2", araddr, arsize);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checks++;
    if ({arvalid, rready, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL lw_t2_valids got %b exp 010", {arvalid, rready, resp_valid});
    end
    rdata = data; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    checks++;
    if ({resp_valid, resp_wen, resp_err, req_ready, rready} !== 5'b11010) begin
      errors++; $display("FAIL lw_t3_flags got %b exp 11010", {resp_valid, resp_wen, resp_err, req_ready, rready});
    end
    checks++;
    if (resp_data !== 32'hDEADBEEF || resp_rd !== 5'd7) begin
      errors++; $display("FAIL lw_data got %h rd %0d exp deadbeef rd 7", resp_data, resp_rd);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse_width got %b exp 0", resp_valid); end
  endtask

  task automatic test_load_byte;
    logic [DATA_W-1:0] data, cw;
    logic [STRB_W-1:0] cs;
    logic [31:0] d;
    logic ok, e, w, sa, sw;
    logic [2:0] cz;
    int lat;
    data = '0;
    data[63:0] = 64'h55555555_807F7F7F;
    send_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd9);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", d); end
    checks++;
    if ({lat, e, w, cz} !== {32'd3, 1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL lb_meta got lat %0d err %b wen %b size %0d exp 3 0 1 0", lat, e, w, cz);
    end
    send_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd9);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (d !== 32'h00000080) begin errors++; $display("FAIL lbu_zero got %h exp 00000080", d); end
  endtask

  task automatic test_store_half;
    logic [DATA_W-1:0] cw;
    logic [STRB_W-1:0] cs;
    logic [31:0] d;
    logic ok, e, w, sa, sw;
    logic [2:0] cz;
    int lat;
    send_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'hABCD1234, 5'd3);
    run_slave('0, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (cs !== 64'h0000_0000_0000_0C00) begin errors++; $display("FAIL sh_wstrb got %h exp 0c00", cs); end
    checks++;
    if (cw[95:80] !== 16'h1234 || cw[15:0] !== 16'h1234) begin
      errors++; $display("FAIL sh_wdata got %h/%h exp 1234/1234", cw[95:80], cw[15:0]);
    end
    checks++;
    if ({lat, e, w, d, cz, sa} !== {32'd3, 1'b0, 1'b0, 32'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL sh_resp got lat %0d err %b wen %b data %h size %0d ar %b exp 3 0 0 0 1 0", lat, e, w, d, cz, sa);
    end
  endtask

  task automatic test_store_delayed;
    int pulses;
    pulses = 0;
    send_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 5'd0);
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, wlast, wstrb} !== {3'b111, 64'hF}) begin
      errors++; $display("FAIL sw_t1 got aw %b w %b last %b strb %h exp 1 1 1 f", awvalid, wvalid, wlast, wstrb);
    end
    checks++;
    if (wdata[31:0] !== 32'hCAFEF00D || wdata[511:480] !== 32'hCAFEF00D || awaddr !== 31'h200) begin
      errors++; $display("FAIL sw_wdata got %h %h addr %h exp cafef00d x2 addr 200", wdata[31:0], wdata[511:480], awaddr);
    end
    awready = 1'b0; wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    pulses += int'(resp_valid);
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      errors++; $display("FAIL sw_w_first got %b exp 100", {awvalid, wvalid, bready});
    end
    @(negedge clk);
    pulses += int'(resp_valid);
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      errors++; $display("FAIL sw_aw_wait got %b exp 100", {awvalid, wvalid, bready});
    end
    @(negedge clk);
    pulses += int'(resp_valid);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    pulses += int'(resp_valid);
    checks++;
    if ({awvalid, wvalid, bready, resp_valid} !== 4'b0010) begin
      errors++; $display("FAIL sw_bready got %b exp 0010", {awvalid, wvalid, bready, resp_valid});
    end
    bresp = 2'b00; bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    pulses += int'(resp_valid);
    checks++;
    if ({resp_valid, resp_wen, resp_err, bready, resp_data} !== {4'b1000, 32'd0}) begin
      errors++; $display("FAIL sw_resp got %b data %h exp 1000 0", {resp_valid, resp_wen, resp_err, bready}, resp_data);
    end
    repeat (2) begin @(negedge clk); pulses += int'(resp_valid); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL sw_one_resp got %0d exp 1", pulses); end
  endtask

  task automatic test_error_and_reset;
    logic [DATA_W-1:0] cw;
    logic [STRB_W-1:0] cs;
    logic [31:0] d;
    logic ok, e, w, sa, sw;
    logic [2:0] cz;
    int lat, pulses;
    send_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 5'd4);
    run_slave({DATA_W{1'b1}}, 2'b10, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({e, w} !== 2'b10) begin errors++; $display("FAIL lw_slverr got err %b wen %b exp 1 0", e, w); end

    send_req(1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 5'd4);
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready} !== 7'b0000001) begin
      errors++; $display("FAIL mid_reset got %b exp 0000001", {arvalid, rready, awvalid, wvalid, bready, resp_valid, req_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    rdata = '1; rresp = 2'b00; rvalid = 1'b1;
    repeat (4) begin @(negedge clk); pulses += int'(resp_valid); end
    rvalid = 1'b0;
    checks++;
    if (pulses !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_abandon got pulses %0d ready %b exp 0 1", pulses, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] data, cw;
    logic [STRB_W-1:0] cs;
    logic [31:0] d;
    logic ok, e, w, sa, sw;
    logic [2:0] cz;
    int lat;
    data = '0;
    data[31:0] = 32'h8001_7777;
    send_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 5'd11);
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rdata = data; rresp = 2'b00; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    checks++;
    if ({resp_valid, req_ready, resp_data} !== {2'b11, 32'h0000_8001}) begin
      errors++; $display("FAIL b2b_lhu got v %b rdy %b data %h exp 1 1 00008001", resp_valid, req_ready, resp_data);
    end
    set_req(1'b1, 2'd0, 1'b0, 32'h45, 32'hFFFF_FF5A, 5'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    run_slave('0, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (cs !== 64'h20 || cw[47:40] !== 8'h5A || cz !== 3'd0) begin
      errors++; $display("FAIL b2b_sb got strb %h byte %h size %0d exp 20 5a 0", cs, cw[47:40], cz);
    end
    checks++;
    if ({lat, e, w} !== {32'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_sb_resp got lat %0d err %b wen %b exp 3 0 0", lat, e, w);
    end
  endtask

  task automatic test_misalign;
    logic [DATA_W-1:0] data, cw;
    logic [STRB_W-1:0] cs;
    logic [31:0] d;
    logic ok, e, w, sa, sw;
    logic [2:0] cz;
    int lat;
    data = '0;
    data[47:16]   = 32'h11223344;
    data[511:496] = 16'hBEEF;
`ifdef LSU_MISALIGN_TRAP_EN
    send_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'd1);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({sa, lat, e, w} !== {1'b0, 32'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL trap_lw got ar %b lat %0d err %b wen %b exp 0 1 1 0", sa, lat, e, w);
    end
    send_req(1'b0, 2'd1, 1'b1, 32'h3, 32'h0, 5'd1);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({sa, lat, e} !== {1'b0, 32'd1, 1'b1}) begin
      errors++; $display("FAIL trap_lh got ar %b lat %0d err %b exp 0 1 1", sa, lat, e);
    end
    send_req(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 5'd0);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({sw, lat, e, w} !== {1'b0, 32'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL trap_size3 got aw %b lat %0d err %b wen %b exp 0 1 1 0", sw, lat, e, w);
    end
`else
    send_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'd1);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({sa, e, d} !== {2'b10, 32'h11223344}) begin
      errors++; $display("FAIL unaligned_lw got ar %b err %b data %h exp 1 0 11223344", sa, e, d);
    end
    send_req(1'b0, 2'd2, 1'b0, 32'h3E, 32'h0, 5'd1);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (d !== 32'h0000BEEF) begin errors++; $display("FAIL lw_top_lane got %h exp 0000beef", d); end
    data[31:0] = 32'h01020304;
    send_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd1);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if ({cz, e, d} !== {3'd2, 1'b0, 32'h01020304}) begin
      errors++; $display("FAIL size3_as_word got size %0d err %b data %h exp 2 0 01020304", cz, e, d);
    end
    send_req(1'b1, 2'd2, 1'b0, 32'h3E, 32'h11223344, 5'd0);
    run_slave(data, 2'b00, 2'b00, ok, lat, d, e, w, sa, sw, cw, cs, cz);
    checks++;
    if (cs !== 64'hC000_0000_0000_0000 || e !== 1'b0) begin
      errors++; $display("FAIL sw_top_lane_strb got %h err %b exp c000000000000000 0", cs, e);
    end
`endif
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_store_delayed();
    test_error_and_reset();
    test_back_to_back();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
